// File: rtl/uart_frame_mux_if.sv
// rtl/uart_frame_mux_if.sv - byte handshake between the frame serializer and the UART transmitter
interface uart_frame_mux_if;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_byte;

  modport master (output tx_valid, output tx_byte, input tx_ready);
  modport slave  (input tx_valid, input tx_byte, output tx_ready);
endinterface

// File: rtl/uart_frame_mux.sv
// rtl/uart_frame_mux.sv - snapshots telemetry channels and serializes sync/channel/checksum words as bytes
module uart_frame_mux #(
  parameter int         NUM_CH         = 6,
  parameter int         FIELD_W        = 12,
  parameter logic [7:0] SYNC_KEY       = 8'h0F,
  parameter bit         CHECKSUM_EN    = 1'b1,
  parameter bit         SKIP_UNCHANGED = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH*FIELD_W-1:0] ch_data,
  input  logic                      con_broken,
  uart_frame_mux_if.master          tx,
  output logic                      frame_start,
  output logic                      frame_done
);
  // Word selector: 0 = sync, 1..NUM_CH = channel sel-1, NUM_CH+1 = checksum
  localparam int               SEL_W    = $clog2(NUM_CH + 2);
  localparam logic [SEL_W-1:0] CSUM_SEL = SEL_W'(NUM_CH + 1);

  localparam logic [1:0] LOAD    = 2'd0;
  localparam logic [1:0] SEND_HI = 2'd1;
  localparam logic [1:0] SEND_LO = 2'd2;
  localparam logic [1:0] NEXT    = 2'd3;

  logic [1:0]                state_q, state_d;
  logic [NUM_CH*FIELD_W-1:0] snap_q, snap_d;
  logic [SEL_W-1:0]          sel_q, sel_d;
  logic [15:0]               word_q, word_d;
  logic [7:0]                csum_q, csum_d;
  logic [11:0]               last_q [NUM_CH];
  logic [11:0]               last_d [NUM_CH];
  logic [NUM_CH-1:0]         last_vld_q, last_vld_d;
  logic                      tx_valid_q, tx_valid_d;
  logic [7:0]                tx_byte_q, tx_byte_d;
  logic                      frame_done_q, frame_done_d;

  logic [11:0]       ch_val [NUM_CH];
  logic [NUM_CH-1:0] send_mask;
  logic              accept;
  logic              later_send;
  logic              last_word;
  logic              cand_is_ch;
  logic              cand_send;
  logic [15:0]       cand_word;

  assign accept = tx_valid_q & tx.tx_ready;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_val[g] = 12'(snap_q[g*FIELD_W +: FIELD_W]);
  end

  // Channel sel_q is both the NEXT candidate and the first channel after the word in SEND_LO
  always_comb begin
    send_mask  = '0;
    later_send = 1'b0;
    cand_is_ch = 1'b0;
    cand_send  = 1'b0;
    cand_word  = {8'hF0, csum_q};
    for (int i = 0; i < NUM_CH; i++) begin
      send_mask[i] = !SKIP_UNCHANGED || !last_vld_q[i] || (ch_val[i] != last_q[i]);
      if (SEL_W'(i) >= sel_q) begin
        later_send = later_send | send_mask[i];
      end
      if (SEL_W'(i) == sel_q) begin
        cand_is_ch = 1'b1;
        cand_send  = send_mask[i];
        cand_word  = {4'(i + 1), ch_val[i]};
      end
    end
  end

  assign last_word = CHECKSUM_EN ? (sel_q == CSUM_SEL) : !later_send;

  always_comb begin
    state_d      = state_q;
    snap_d       = snap_q;
    sel_d        = sel_q;
    word_d       = word_q;
    csum_d       = csum_q;
    last_d       = last_q;
    last_vld_d   = last_vld_q;
    frame_done_d = 1'b0;

    case (state_q)
      LOAD: begin
        snap_d  = ch_data;
        csum_d  = 8'h00;
        sel_d   = '0;
        word_d  = {SYNC_KEY, 8'h00};
        state_d = SEND_HI;
      end
      SEND_HI: begin
        if (accept) begin
          state_d = SEND_LO;
        end
      end
      SEND_LO: begin
        if (accept) begin
          state_d      = NEXT;
          frame_done_d = last_word;
          if (sel_q != '0 && sel_q != CSUM_SEL) begin
            csum_d = csum_q ^ word_q[15:8] ^ word_q[7:0];
            for (int i = 0; i < NUM_CH; i++) begin
              if (SEL_W'(i + 1) == sel_q) begin
                last_d[i]     = word_q[11:0];
                last_vld_d[i] = 1'b1;
              end
            end
          end
        end
      end
      NEXT: begin
        sel_d = sel_q + SEL_W'(1);
        if (frame_done_q) begin
          state_d = LOAD;
        end else if (cand_is_ch) begin
          // A skipped channel leaves us in NEXT for exactly one more cycle
          if (cand_send) begin
            word_d  = cand_word;
            state_d = SEND_HI;
          end
        end else if (CHECKSUM_EN) begin
          word_d  = cand_word;
          state_d = SEND_HI;
        end else begin
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    if (con_broken) begin
      state_d      = LOAD;
      frame_done_d = 1'b0;
      last_vld_d   = '0;
    end

    tx_valid_d = (state_d == SEND_HI) || (state_d == SEND_LO);
    if (state_d == SEND_HI) begin
      tx_byte_d = word_d[15:8];
    end else if (state_d == SEND_LO) begin
      tx_byte_d = word_d[7:0];
    end else begin
      tx_byte_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      snap_q       <= '0;
      sel_q        <= '0;
      word_q       <= '0;
      csum_q       <= 8'h00;
      last_vld_q   <= '0;
      tx_valid_q   <= 1'b0;
      tx_byte_q    <= 8'h00;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      snap_q       <= snap_d;
      sel_q        <= sel_d;
      word_q       <= word_d;
      csum_q       <= csum_d;
      last_vld_q   <= last_vld_d;
      tx_valid_q   <= tx_valid_d;
      tx_byte_q    <= tx_byte_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Payload history is only trusted through last_vld_q, so it needs no reset
  always_ff @(posedge clk) begin
    last_q <= last_d;
  end

  assign tx.tx_valid = tx_valid_q;
  assign tx.tx_byte  = tx_byte_q;
  assign frame_done  = frame_done_q;
  // The LOAD cycle itself carries the pulse; held low while rst is asserted
  assign frame_start = (state_q == LOAD) && !rst;

endmodule

// File: tb/tb_uart_frame_mux.sv
// tb/tb_uart_frame_mux.sv - directed-vector bench for uart_frame_mux
module tb_uart_frame_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // {frame_start, frame_done, tx_valid, tx_byte} per cycle from LOAD, tx_ready held high
  logic [10:0] exp_a [14] = '{11'h400, 11'h10F, 11'h100, 11'h000, 11'h11A, 11'h1BC, 11'h000,
                              11'h121, 11'h123, 11'h000, 11'h1F0, 11'h1A4, 11'h200, 11'h400};
  logic [10:0] exp_c [8]  = '{11'h400, 11'h10F, 11'h100, 11'h000, 11'h110, 11'h1FF, 11'h200, 11'h400};
  logic [7:0]  exp_b [29] = '{8'h0F, 8'h00, 8'h1A, 8'hBC, 8'h21, 8'h23, 8'hF0, 8'hA4,
                              8'h0F, 8'h00, 8'hF0, 8'h00,
                              8'h0F, 8'h00, 8'h21, 8'h24, 8'hF0, 8'h05,
                              8'h0F, 8'h00, 8'h1A,
                              8'h0F, 8'h00, 8'h1A, 8'hBD, 8'h21, 8'h24, 8'hF0, 8'hA2};

  // DUT A: two channels, checksum, no skipping
  logic        rst_a = 1'b1, cb_a = 1'b0, fs_a, fd_a;
  logic [23:0] ch_a = {12'h123, 12'hABC};
  uart_frame_mux_if if_a ();
  uart_frame_mux #(.NUM_CH(2), .FIELD_W(12), .SYNC_KEY(8'h0F), .CHECKSUM_EN(1'b1), .SKIP_UNCHANGED(1'b0))
    dut_a (.clk(clk), .rst(rst_a), .ch_data(ch_a), .con_broken(cb_a), .tx(if_a),
           .frame_start(fs_a), .frame_done(fd_a));

  // DUT B: two channels, checksum, skip unchanged
  logic        rst_b = 1'b1, cb_b = 1'b0, fs_b, fd_b;
  logic [23:0] ch_b = {12'h123, 12'hABC};
  uart_frame_mux_if if_b ();
  uart_frame_mux #(.NUM_CH(2), .FIELD_W(12), .SYNC_KEY(8'h0F), .CHECKSUM_EN(1'b1), .SKIP_UNCHANGED(1'b1))
    dut_b (.clk(clk), .rst(rst_b), .ch_data(ch_b), .con_broken(cb_b), .tx(if_b),
           .frame_start(fs_b), .frame_done(fd_b));

  // DUT C: one 8-bit channel, no checksum
  logic       rst_c = 1'b1, cb_c = 1'b0, fs_c, fd_c;
  logic [7:0] ch_c = 8'hFF;
  uart_frame_mux_if if_c ();
  uart_frame_mux #(.NUM_CH(1), .FIELD_W(8), .SYNC_KEY(8'h0F), .CHECKSUM_EN(1'b0), .SKIP_UNCHANGED(1'b0))
    dut_c (.clk(clk), .rst(rst_c), .ch_data(ch_c), .con_broken(cb_c), .tx(if_c),
           .frame_start(fs_c), .frame_done(fd_c));

  logic [7:0] cap_a [$];
  logic [7:0] cap_b [$];
  int         fd_cyc_b [$];
  int         fd_cnt_a = 0, fd_cnt_b = 0, hold_viol_a = 0;
  logic       hold_pend_a = 1'b0;
  logic [7:0] hold_byte_a = 8'h00;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (if_a.tx_valid === 1'b1 && if_a.tx_ready === 1'b1) cap_a.push_back(if_a.tx_byte);
    if (fd_a === 1'b1) fd_cnt_a <= fd_cnt_a + 1;
    if (hold_pend_a && (if_a.tx_valid !== 1'b1 || if_a.tx_byte !== hold_byte_a))
      hold_viol_a <= hold_viol_a + 1;
    hold_pend_a <= (if_a.tx_valid === 1'b1) && (if_a.tx_ready === 1'b0) && !rst_a;
    hold_byte_a <= if_a.tx_byte;
    if (if_b.tx_valid === 1'b1 && if_b.tx_ready === 1'b1) cap_b.push_back(if_b.tx_byte);
    if (fd_b === 1'b1) begin
      fd_cnt_b <= fd_cnt_b + 1;
      fd_cyc_b.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin
    int ab, fa, cb0, fb0, fq0, phase;
    if_a.tx_ready = 1'b1;
    if_b.tx_ready = 1'b1;
    if_c.tx_ready = 1'b1;

    // A: reset values, then one full frame cycle by cycle
    @(posedge clk); #1;
    check("A_rst_valid", 32'(if_a.tx_valid), 32'd0);
    check("A_rst_byte", 32'(if_a.tx_byte), 32'd0);
    check("A_rst_fs", 32'(fs_a), 32'd0);
    check("A_rst_fd", 32'(fd_a), 32'd0);
    rst_a = 1'b0; #1;
    for (int c = 0; c < 14; c++) begin
      check($sformatf("A_cyc%0d", c), 32'({fs_a, fd_a, if_a.tx_valid, if_a.tx_byte}), 32'(exp_a[c]));
      @(posedge clk); #1;
    end

    // A: reset in the middle of the second frame
    repeat (3) begin @(posedge clk); #1; end
    check("A_mid_pre", 32'(if_a.tx_byte), 32'h1A);
    rst_a = 1'b1;
    @(posedge clk); #1;
    check("A_mid_valid", 32'(if_a.tx_valid), 32'd0);
    check("A_mid_byte", 32'(if_a.tx_byte), 32'd0);
    check("A_mid_fs", 32'(fs_a), 32'd0);
    check("A_mid_fd", 32'(fd_a), 32'd0);
    rst_a = 1'b0; #1;
    check("A_mid_load", 32'({fs_a, if_a.tx_valid}), 32'b10);
    @(posedge clk); #1;
    check("A_mid_sync", 32'({if_a.tx_valid, if_a.tx_byte}), 32'h10F);

    // A: random back-pressure, same byte sequence
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    ab = cap_a.size();
    fa = fd_cnt_a;
    for (int c = 0; c < 400 && fd_cnt_a == fa; c++) begin
      if_a.tx_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    if_a.tx_ready = 1'b1;
    check("A_rand_fd", 32'(fd_cnt_a - fa), 32'd1);
    check("A_rand_len", 32'(cap_a.size() - ab), 32'd8);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("A_rand_b%0d", k), 32'((ab + k < cap_a.size()) ? cap_a[ab + k] : 8'hxx), 32'(exp_b[k]));
    end
    check("A_hold", 32'(hold_viol_a), 32'd0);

    // C: single 8-bit channel, no checksum
    @(posedge clk); #1;
    check("C_rst_valid", 32'(if_c.tx_valid), 32'd0);
    rst_c = 1'b0; #1;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("C_cyc%0d", c), 32'({fs_c, fd_c, if_c.tx_valid, if_c.tx_byte}), 32'(exp_c[c]));
      @(posedge clk); #1;
    end

    // B: full, skip, partial, aborted and recovered frames
    @(posedge clk); #1;
    rst_b = 1'b0;
    cb0 = cap_b.size();
    fb0 = fd_cnt_b;
    fq0 = fd_cyc_b.size();
    phase = 0;
    for (int c = 0; c < 400 && fd_cnt_b < fb0 + 4; c++) begin
      @(posedge clk); #1;
      if (phase == 0 && fd_cnt_b == fb0 + 2) begin
        ch_b[23:12] = 12'h124;
        phase = 1;
      end else if (phase == 1 && fd_cnt_b == fb0 + 3) begin
        ch_b[11:0] = 12'hABD;
        phase = 2;
      end else if (phase == 2 && cap_b.size() == cb0 + 21) begin
        cb_b = 1'b1;
        if_b.tx_ready = 1'b0;
        phase = 3;
      end else if (phase == 3) begin
        cb_b = 1'b0;
        if_b.tx_ready = 1'b1;
        check("B_cb_valid", 32'(if_b.tx_valid), 32'd0);
        check("B_cb_fs", 32'(fs_b), 32'd1);
        check("B_cb_fd", 32'(fd_b), 32'd0);
        phase = 4;
      end
    end
    check("B_frames", 32'(fd_cnt_b - fb0), 32'd4);
    check("B_len", 32'(cap_b.size() - cb0), 32'd29);
    for (int k = 0; k < 29; k++) begin
      check($sformatf("B_b%0d", k), 32'((cb0 + k < cap_b.size()) ? cap_b[cb0 + k] : 8'hxx), 32'(exp_b[k]));
    end
    if (fd_cyc_b.size() >= fq0 + 4) begin
      check("B_skip_frame_len", 32'(fd_cyc_b[fq0 + 1] - fd_cyc_b[fq0]), 32'd9);
      check("B_part_frame_len", 32'(fd_cyc_b[fq0 + 2] - fd_cyc_b[fq0 + 1]), 32'd11);
      check("B_abort_gap", 32'(fd_cyc_b[fq0 + 3] - fd_cyc_b[fq0 + 2]), 32'd19);
    end else begin
      check("B_fd_events", 32'(fd_cyc_b.size() - fq0), 32'd4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
